// File: rtl/coherency_snoop_if.sv
// coherency_snoop_if: snoop request, cache coherence port and writeback beat signals.
// The controller uses the slave modport. The bus/cache side uses master.
interface coherency_snoop_if #(
   parameter int N_SETS     = 16,
   parameter int BLOCK_SIZE = 2
);
   localparam int SET_W  = $clog2(N_SETS);
   localparam int WORD_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   logic              snoop_req;
   logic              snoop_inv;
   logic [31:0]       snoop_addr;
   logic              snoop_ack;
   logic              snoop_hit;
   logic              snoop_dirty;
   logic [SET_W-1:0]  set_sel;
   logic [WORD_W-1:0] word_sel;
   logic [1:0]        state_transfer;
   logic              cc_update;
   logic              valid;
   logic              exclusive;
   logic              dirty;
   logic [31:0]       requested_data;
   logic              wb_valid;
   logic [31:0]       wb_data;
   logic              wb_ready;
   modport slave (
      input  snoop_req, snoop_inv, snoop_addr, valid, exclusive, dirty, requested_data, wb_ready,
      output snoop_ack, snoop_hit, snoop_dirty, set_sel, word_sel, state_transfer, cc_update,
             wb_valid, wb_data
   );
   modport master (
      output snoop_req, snoop_inv, snoop_addr, valid, exclusive, dirty, requested_data, wb_ready,
      input  snoop_ack, snoop_hit, snoop_dirty, set_sel, word_sel, state_transfer, cc_update,
             wb_valid, wb_data
   );
endinterface

// File: rtl/coherency_snoop_ctrl.sv
// coherency_snoop_ctrl: snoop-side MESI controller that looks up a line, writes it back if it is dirty,
// commands the cache state change and then acknowledges the snoop.
module coherency_snoop_ctrl #(
   parameter int N_SETS     = 16,
   parameter int BLOCK_SIZE = 2
) (
   input logic CLK,
   input logic RST,
   coherency_snoop_if.slave bus
);
   localparam int SET_W  = $clog2(N_SETS);
   localparam int WORD_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BLOCK_SIZE - 1);
   localparam logic [1:0] SHARED  = 2'd2;
   localparam logic [1:0] INVALID = 2'd3;

   typedef enum logic [2:0] {IDLE, LOOKUP, WB, UPDATE, RESP} state_t;

   state_t            state_q, state_d;
   logic [SET_W-1:0]  set_q, set_d;
   logic [WORD_W-1:0] beat_q, beat_d;
   logic [1:0]        st_q, st_d;
   logic              inv_q, inv_d;
   logic              hit_q, hit_d;
   logic              dirty_q, dirty_d;
   logic              unused_in;

   // E and S lines take the same transition, so the exclusive bit is not needed.
   assign unused_in = ^{bus.snoop_addr, bus.exclusive};

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         set_q   <= '0;
         beat_q  <= '0;
         st_q    <= INVALID;
         inv_q   <= 1'b0;
         hit_q   <= 1'b0;
         dirty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         beat_q  <= beat_d;
         st_q    <= st_d;
         inv_q   <= inv_d;
         hit_q   <= hit_d;
         dirty_q <= dirty_d;
      end
   end

   always_comb begin
      state_d = state_q;
      set_d   = set_q;
      beat_d  = beat_q;
      st_d    = st_q;
      inv_d   = inv_q;
      hit_d   = hit_q;
      dirty_d = dirty_q;
      case (state_q)
         IDLE: if (bus.snoop_req) begin
            set_d   = bus.snoop_addr[2+WORD_W +: SET_W];
            inv_d   = bus.snoop_inv;
            state_d = LOOKUP;
         end
         LOOKUP: begin
            hit_d   = bus.valid;
            dirty_d = bus.valid & bus.dirty;
            beat_d  = '0;
            state_d = !bus.valid ? RESP : bus.dirty ? WB : UPDATE;
         end
         WB: if (bus.wb_ready) begin
            beat_d  = beat_q + 1'b1;
            state_d = (beat_q == LAST_BEAT) ? UPDATE : WB;
         end
         UPDATE: begin
            st_d    = inv_q ? INVALID : SHARED;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.set_sel        = set_q;
   assign bus.word_sel       = (state_q == WB) ? beat_q : '0;
   assign bus.wb_valid       = (state_q == WB);
   assign bus.wb_data        = (state_q == WB) ? bus.requested_data : '0;
   assign bus.cc_update      = (state_q == UPDATE);
   assign bus.state_transfer = (state_q == UPDATE) ? st_d : st_q;
   assign bus.snoop_ack      = (state_q == RESP);
   assign bus.snoop_hit      = (state_q == RESP) & hit_q;
   assign bus.snoop_dirty    = (state_q == RESP) & dirty_q;
endmodule

// File: tb/tb_coherency_snoop_ctrl.sv
// tb_coherency_snoop_ctrl: directed and randomized snoops checked against a MESI reference model
// of the cache and the bus timing.
module tb_coherency_snoop_ctrl;
   localparam int N_SETS = 16;
   localparam int BS     = 2;
   localparam int WORD_W = (BS > 1) ? $clog2(BS) : 1;
   localparam int M = 0, E = 1, S = 2, I = 3;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   coherency_snoop_if #(.N_SETS(N_SETS), .BLOCK_SIZE(BS)) bus ();
   coherency_snoop_ctrl #(.N_SETS(N_SETS), .BLOCK_SIZE(BS)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

   logic        cv [N_SETS];
   logic        ce [N_SETS];
   logic        cd [N_SETS];
   logic [31:0] cmem [N_SETS][BS];
   int total = 0;
   int bad   = 0;

   assign bus.valid          = cv[bus.set_sel];
   assign bus.exclusive      = ce[bus.set_sel];
   assign bus.dirty          = cd[bus.set_sel];
   assign bus.requested_data = cmem[bus.set_sel][bus.word_sel];

   always @(posedge CLK)
      if (!RST && bus.cc_update) begin
         cv[bus.set_sel] <= (bus.state_transfer != 2'd3);
         ce[bus.set_sel] <= (bus.state_transfer == 2'd1);
         cd[bus.set_sel] <= (bus.state_transfer == 2'd0);
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int mesi_of(input int s);
      if (!cv[s]) return I;
      if (cd[s]) return M;
      return ce[s] ? E : S;
   endfunction

   task automatic set_line(input int s, input int st);
      cv[s] = (st != I);
      ce[s] = (st == E);
      cd[s] = (st == M);
      for (int w = 0; w < BS; w++) cmem[s][w] = $urandom();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"}, 32'(bus.snoop_ack), 0);
      chk({tag, "_hit"}, 32'(bus.snoop_hit), 0);
      chk({tag, "_dirty"}, 32'(bus.snoop_dirty), 0);
      chk({tag, "_cc"}, 32'(bus.cc_update), 0);
      chk({tag, "_wbv"}, 32'(bus.wb_valid), 0);
      chk({tag, "_wbd"}, bus.wb_data, 0);
      chk({tag, "_set"}, 32'(bus.set_sel), 0);
      chk({tag, "_word"}, 32'(bus.word_sel), 0);
      chk({tag, "_st"}, 32'(bus.state_transfer), I);
   endtask

   function automatic logic [31:0] addr_for(input int s);
      logic [31:0] lo_mask;
      lo_mask = (32'd1 << (2 + WORD_W)) - 1;
      return ($urandom() & ~((32'(N_SETS) << (2 + WORD_W)) - 1)) | (32'(s) << (2 + WORD_W)) | ($urandom() & lo_mask);
   endfunction

   // stall: 0 ready high, 1 random ready, 2 ready low for three cycles on beat 0.
   // keep: leave snoop_req high after the ack so the next request goes back-to-back, with snoop_inv = next_inv.
   task automatic snoop(input logic [31:0] addr, input logic inv, input int stall, input bit keep, input logic next_inv);
      int s, cur, exp_new, beats, stalls, cc_cnt, cc_cyc, ack_cyc, exp_ack;
      bit exp_hit, exp_dirty, prev_stall;
      logic [31:0] words [BS];
      logic [31:0] prev_data;
      s = int'((addr >> (2 + WORD_W)) % N_SETS);
      cur = mesi_of(s);
      exp_hit = cv[s];
      exp_dirty = (cur == M);
      exp_new = (cur == I) ? I : (inv ? I : S);
      for (int w = 0; w < BS; w++) words[w] = cmem[s][w];
      bus.snoop_addr = addr;
      bus.snoop_inv = inv;
      bus.snoop_req = 1'b1;
      bus.wb_ready = 1'b0;
      beats = 0; stalls = 0; cc_cnt = 0; cc_cyc = -1; ack_cyc = -1; prev_stall = 0; prev_data = '0;
      @(posedge CLK);
      for (int k = 1; k <= 200 && ack_cyc < 0; k++) begin
         @(negedge CLK);
         bus.wb_ready = 1'b0;
         if (bus.wb_valid) begin
            if (prev_stall) chk("wb_stable", bus.wb_data, prev_data);
            chk("wb_data", bus.wb_data, (beats < BS) ? words[beats] : 32'hDEAD_BEEF);
            bus.wb_ready = (stall == 0) ? 1'b1 : (stall == 1) ? 1'($urandom_range(0, 1)) : (beats > 0 || stalls >= 3);
            if (bus.wb_ready) beats++; else stalls++;
            prev_stall = !bus.wb_ready;
            prev_data = bus.wb_data;
         end
         if (bus.cc_update) begin
            cc_cnt++;
            cc_cyc = k;
            chk("state_transfer", 32'(bus.state_transfer), exp_new);
         end
         if (bus.snoop_ack) begin
            ack_cyc = k;
            chk("snoop_hit", 32'(bus.snoop_hit), 32'(exp_hit));
            chk("snoop_dirty", 32'(bus.snoop_dirty), 32'(exp_dirty));
            if (keep) bus.snoop_inv = next_inv; else bus.snoop_req = 1'b0;
         end
      end
      exp_ack = !exp_hit ? 2 : !exp_dirty ? 3 : 3 + BS + stalls;
      chk("ack_latency", 32'(ack_cyc), 32'(exp_ack));
      chk("cc_count", 32'(cc_cnt), exp_hit ? 1 : 0);
      if (exp_hit) chk("cc_cycle", 32'(cc_cyc), 32'(ack_cyc - 1));
      chk("wb_beats", 32'(beats), exp_dirty ? BS : 0);
      bus.wb_ready = 1'b0;
      @(negedge CLK);
      chk("ack_pulse", 32'(bus.snoop_ack), 0);
      chk("line_state", 32'(mesi_of(s)), 32'(exp_new));
   endtask

   initial begin
      logic [31:0] a;
      bit seen;
      bus.snoop_req = 1'b0;
      bus.snoop_inv = 1'b0;
      bus.snoop_addr = '0;
      bus.wb_ready = 1'b0;
      for (int s = 0; s < N_SETS; s++) set_line(s, I);
      repeat (2) @(negedge CLK);
      chk_reset_outputs("reset");
      RST = 1'b0;
      @(negedge CLK);

      // BusRd on a Modified line: two beats, SHARED update, dirty ack.
      set_line(9, M);
      snoop(32'h0000_0048, 1'b0, 0, 0, 1'b0);
      // BusRdX on an Exclusive line in set 5.
      set_line(5, E);
      snoop(addr_for(5), 1'b1, 0, 0, 1'b0);
      // Invalid line with a stale dirty bit is a miss.
      set_line(3, I);
      cd[3] = 1'b1;
      snoop(addr_for(3), 1'b0, 0, 0, 1'b0);
      chk("inv_dirty_kept", 32'(cd[3]), 1);
      // BusRdX on a Modified line with the bus stalling beat 0.
      set_line(12, M);
      snoop(addr_for(12), 1'b1, 2, 0, 1'b0);
      // Back-to-back BusRd and then BusRdX on the same Shared line.
      set_line(7, S);
      a = addr_for(7);
      snoop(a, 1'b0, 0, 1, 1'b1);
      snoop(a, 1'b1, 0, 0, 1'b0);

      // Reset in the middle of a writeback abandons the snoop.
      set_line(10, M);
      bus.snoop_addr = addr_for(10);
      bus.snoop_inv = 1'b1;
      bus.snoop_req = 1'b1;
      @(posedge CLK);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge CLK);
         bus.wb_ready = 1'b1;
         if (bus.wb_valid && bus.word_sel == WORD_W'(1)) seen = 1;
      end
      chk("reach_beat1", 32'(seen), 1);
      RST = 1'b1;
      bus.snoop_req = 1'b0;
      bus.wb_ready = 1'b0;
      @(negedge CLK);
      chk_reset_outputs("mid_wb_reset");
      RST = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("post_rst_ack", 32'(bus.snoop_ack), 0);
         chk("post_rst_cc", 32'(bus.cc_update), 0);
      end
      chk("post_rst_line", 32'(mesi_of(10)), M);

      // Randomized snoops against the reference model.
      for (int n = 0; n < 40; n++) begin
         int s;
         s = $urandom_range(0, N_SETS - 1);
         set_line(s, $urandom_range(0, 3));
         if (!cv[s]) cd[s] = 1'($urandom_range(0, 1));
         snoop(addr_for(s), 1'($urandom_range(0, 1)), 1, 0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
